// File: rtl/minmax_pkg.sv
// Shared types and sizing for the windowed min/max tracker.
package minmax_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ACC   = 2'd1,
      HOLD  = 2'd2
   } state_e;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_WIN   = 16;

   // Sample counter / index width; never below one bit.
   function automatic int cnt_w(input int win);
      return (win <= 2) ? 1 : $clog2(win);
   endfunction

endpackage

// File: rtl/minmax_tracker_if.sv
// Sample intake and result handshake bundle for minmax_tracker.
// Index signals exist only when MINMAX_IDX_EN is defined.
interface minmax_tracker_if
   import minmax_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int WIN   = DEF_WIN
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_max;
   logic [WIDTH-1:0] out_min;
`ifdef MINMAX_IDX_EN
   localparam int IDX_W = cnt_w(WIN);
   logic [IDX_W-1:0] out_max_idx;
   logic [IDX_W-1:0] out_min_idx;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_max, out_min, out_max_idx, out_min_idx
   );
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_max, out_min, out_max_idx, out_min_idx
   );
`else
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_max, out_min
   );
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_max, out_min
   );
`endif
endinterface

// File: rtl/minmax_tracker_mag_cmp.sv
// Unsigned magnitude comparator; gt and lt are both low on equality.
module mag_cmp #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             gt,
   output logic             lt
);
   assign gt = (a > b);
   assign lt = (a < b);
endmodule

// File: rtl/minmax_tracker.sv
// Windowed running max/min over WIN unsigned samples with a held result.
// Define MINMAX_IDX_EN to also report the 0-based index of each extreme.
//
// state | meaning
// EMPTY | no sample in the current window
// ACC   | 1..WIN-1 samples held
// HOLD  | result presented, intake stalled until taken
module minmax_tracker
   import minmax_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int WIN   = DEF_WIN
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   minmax_tracker_if.slave  bus
);
   localparam int            CW       = cnt_w(WIN);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIN - 1);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] cur_max_q, cur_max_d, cur_min_q, cur_min_d;
   logic [WIDTH-1:0] out_max_q, out_max_d, out_min_q, out_min_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] nxt_max, nxt_min;
   logic             gt_max, lt_max, gt_min, lt_min;
   logic             accept;
   logic             unused_cmp;
`ifdef MINMAX_IDX_EN
   logic [CW-1:0]    cur_max_idx_q, cur_max_idx_d, cur_min_idx_q, cur_min_idx_d;
   logic [CW-1:0]    out_max_idx_q, out_max_idx_d, out_min_idx_q, out_min_idx_d;
   logic [CW-1:0]    nxt_max_idx, nxt_min_idx;
`endif

   mag_cmp #(.WIDTH(WIDTH)) u_cmp_max (
      .a(bus.in_data), .b(cur_max_q), .gt(gt_max), .lt(lt_max)
   );
   mag_cmp #(.WIDTH(WIDTH)) u_cmp_min (
      .a(bus.in_data), .b(cur_min_q), .gt(gt_min), .lt(lt_min)
   );
   assign unused_cmp = lt_max | gt_min;

   assign bus.in_ready  = (state_q != HOLD);
   assign bus.out_valid = out_valid_q;
   assign bus.out_max   = out_max_q;
   assign bus.out_min   = out_min_q;
   assign accept        = bus.in_valid && bus.in_ready;

   // Strict compares so ties keep the earlier value and index.
   assign nxt_max = gt_max ? bus.in_data : cur_max_q;
   assign nxt_min = lt_min ? bus.in_data : cur_min_q;
`ifdef MINMAX_IDX_EN
   assign nxt_max_idx     = gt_max ? cnt_q : cur_max_idx_q;
   assign nxt_min_idx     = lt_min ? cnt_q : cur_min_idx_q;
   assign bus.out_max_idx = out_max_idx_q;
   assign bus.out_min_idx = out_min_idx_q;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cur_max_d   = cur_max_q;
      cur_min_d   = cur_min_q;
      out_max_d   = out_max_q;
      out_min_d   = out_min_q;
      out_valid_d = out_valid_q;
`ifdef MINMAX_IDX_EN
      cur_max_idx_d = cur_max_idx_q;
      cur_min_idx_d = cur_min_idx_q;
      out_max_idx_d = out_max_idx_q;
      out_min_idx_d = out_min_idx_q;
`endif
      if (clear) begin
         state_d     = EMPTY;
         cnt_d       = '0;
         out_valid_d = 1'b0;
      end else begin
         case (state_q)
            EMPTY: if (accept) begin
               cur_max_d = bus.in_data;
               cur_min_d = bus.in_data;
               cnt_d     = CW'(1);
               state_d   = ACC;
`ifdef MINMAX_IDX_EN
               cur_max_idx_d = '0;
               cur_min_idx_d = '0;
`endif
            end
            ACC: if (accept) begin
               cur_max_d = nxt_max;
               cur_min_d = nxt_min;
`ifdef MINMAX_IDX_EN
               cur_max_idx_d = nxt_max_idx;
               cur_min_idx_d = nxt_min_idx;
`endif
               if (cnt_q == CNT_LAST) begin
                  out_max_d   = nxt_max;
                  out_min_d   = nxt_min;
                  out_valid_d = 1'b1;
                  cnt_d       = '0;
                  state_d     = HOLD;
`ifdef MINMAX_IDX_EN
                  out_max_idx_d = nxt_max_idx;
                  out_min_idx_d = nxt_min_idx;
`endif
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            HOLD: if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = EMPTY;
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         cnt_q       <= '0;
         cur_max_q   <= '0;
         cur_min_q   <= '0;
         out_max_q   <= '0;
         out_min_q   <= '0;
         out_valid_q <= 1'b0;
`ifdef MINMAX_IDX_EN
         cur_max_idx_q <= '0;
         cur_min_idx_q <= '0;
         out_max_idx_q <= '0;
         out_min_idx_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cur_max_q   <= cur_max_d;
         cur_min_q   <= cur_min_d;
         out_max_q   <= out_max_d;
         out_min_q   <= out_min_d;
         out_valid_q <= out_valid_d;
`ifdef MINMAX_IDX_EN
         cur_max_idx_q <= cur_max_idx_d;
         cur_min_idx_q <= cur_min_idx_d;
         out_max_idx_q <= out_max_idx_d;
         out_min_idx_q <= out_min_idx_d;
`endif
      end
   end

endmodule

// File: tb/tb_minmax_tracker.sv
// Scoreboard bench for minmax_tracker (WIN=4): window model predicts results, monitor checks them.
module tb_minmax_tracker;
   localparam int WIDTH = 8;
   localparam int WIN   = 4;

   typedef struct {
      int mx;
      int mn;
      int mxi;
      int mni;
   } res_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0;

   always #5 clk = ~clk;

   minmax_tracker_if #(.WIDTH(WIDTH), .WIN(WIN)) bus ();

   minmax_tracker #(.WIDTH(WIDTH), .WIN(WIN)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .clear(clear),
      .bus  (bus)
   );

   res_t exp_q[$];
   int   win_q[$];
   bit   pending = 1'b0;
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Extremes of the window; first occurrence wins on ties.
   function automatic res_t window_result();
      res_t r;
      r.mx = win_q[0]; r.mn = win_q[0]; r.mxi = 0; r.mni = 0;
      for (int i = 1; i < win_q.size(); i++) begin
         if (win_q[i] > r.mx) begin r.mx = win_q[i]; r.mxi = i; end
         if (win_q[i] < r.mn) begin r.mn = win_q[i]; r.mni = i; end
      end
      return r;
   endfunction

   task automatic cyc(input bit v, input int d, input bit ordy, input bit clr);
      @(negedge clk);
      chk("in_ready", bus.in_ready, !pending);
      chk("out_valid", bus.out_valid, pending);
      bus.in_valid  = v;
      bus.in_data   = d[7:0];
      bus.out_ready = ordy;
      clear         = clr;
      if (clr) begin
         win_q.delete();
         pending = 1'b0;
      end else if (pending) begin
         if (ordy) pending = 1'b0;
      end else if (v) begin
         win_q.push_back(d & 255);
         if (win_q.size() == WIN) begin
            exp_q.push_back(window_result());
            win_q.delete();
            pending = 1'b1;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      clear         = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_max", bus.out_max, 0);
      chk("rst_out_min", bus.out_min, 0);
      chk("rst_in_ready", bus.in_ready, 1);
`ifdef MINMAX_IDX_EN
      chk("rst_max_idx", bus.out_max_idx, 0);
      chk("rst_min_idx", bus.out_min_idx, 0);
`endif
      win_q.delete();
      exp_q.delete();
      pending = 1'b0;
      #1 rst_n = 1'b1;
   endtask

   task automatic window4(input int a, input int b, input int c, input int d, input bit ordy);
      cyc(1, a, ordy, 0);
      cyc(1, b, ordy, 0);
      cyc(1, c, ordy, 0);
      cyc(1, d, ordy, 0);
   endtask

   // Monitor: checks each result when it appears, its stability while held, and retires it.
   initial begin
      logic       pv = 1'b0;
      logic [7:0] pmx = '0, pmn = '0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            pv = 1'b0;
         end else begin
            if (bus.out_valid && !pv) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_result: got max=%0d min=%0d expected none", bus.out_max, bus.out_min);
               end else begin
                  chk("out_max", bus.out_max, exp_q[0].mx);
                  chk("out_min", bus.out_min, exp_q[0].mn);
`ifdef MINMAX_IDX_EN
                  chk("out_max_idx", bus.out_max_idx, exp_q[0].mxi);
                  chk("out_min_idx", bus.out_min_idx, exp_q[0].mni);
`endif
               end
            end else if (bus.out_valid && pv) begin
               chk("max_stable", bus.out_max, pmx);
               chk("min_stable", bus.out_min, pmn);
            end
            if (bus.out_valid && (bus.out_ready || clear) && exp_q.size() > 0)
               void'(exp_q.pop_front());
            pv  = bus.out_valid;
            pmx = bus.out_max;
            pmn = bus.out_min;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      do_reset();

      // back-to-back window, consumer always ready
      window4(5, 9, 2, 7, 1);
      cyc(1, 11, 1, 0);
      cyc(0, 0, 1, 0);

      // all ties, then unsigned extremes
      window4(3, 3, 3, 3, 1);
      cyc(0, 0, 1, 0);
      window4(8'h00, 8'hFF, 8'h80, 8'h01, 1);
      cyc(0, 0, 1, 0);

      // consumer stalls 10 cycles while samples are offered
      window4(20, 40, 10, 30, 0);
      repeat (10) cyc(1, $urandom_range(0, 255), 0, 0);
      cyc(1, 77, 1, 0);
      window4(50, 60, 70, 55, 1);
      cyc(0, 0, 1, 0);

      // clear mid-window (same-cycle sample dropped), then clear racing the handshake
      cyc(1, 200, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(1, 99, 0, 1);
      window4(6, 1, 4, 8, 0);
      cyc(1, 50, 1, 1);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);

      // async reset mid-window and while a result is held
      cyc(1, 250, 1, 0);
      cyc(1, 3, 1, 0);
      do_reset();
      window4(12, 14, 13, 11, 0);
      cyc(0, 0, 0, 0);
      do_reset();
      window4(100, 90, 110, 95, 1);
      cyc(0, 0, 1, 0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         int d;
         d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255);
         cyc($urandom_range(0, 9) < 7, d, $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
      end

      repeat (10) cyc(0, 0, 1, 0);
      chk("queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
